// File: rtl/uart_alu_intf.sv
// Command interpreter between the UART RX FIFO and the TX FIFO. It pops the bytes
// A, B and opcode, evaluates them in a small ALU and pushes one result byte.
module uart_alu_intf #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_rx_empty,
    input  logic [NB_DATA-1:0] i_rx_data,
    output logic               o_rx_rd,
    input  logic               i_tx_full,
    output logic               o_tx_wr,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_result
);

    typedef enum logic [3:0] {
        WAIT_A,
        POP_A,
        WAIT_B,
        POP_B,
        WAIT_OP,
        POP_OP,
        EXEC,
        SEND,
        WR
    } state_t;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'('h20);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'('h22);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'('h24);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'('h25);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'('h26);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'('h27);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'('h03);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'('h02);

    localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA'(NB_DATA);

    state_t                    state;
    logic        [NB_DATA-1:0] reg_a;
    logic        [NB_DATA-1:0] reg_b;
    logic        [NB_OP-1:0]   reg_op;
    logic        [NB_DATA-1:0] result;
    logic        [NB_DATA-1:0] alu_res;
    logic signed [NB_DATA-1:0] sra_val;

    // The arithmetic shift is kept in its own signed variable so that the
    // surrounding unsigned select cannot turn it into a logical shift.
    always_comb begin
        sra_val = $signed(reg_a) >>> reg_b;
        alu_res = '0;
        case (reg_op)
            OP_ADD:  alu_res = reg_a + reg_b;
            OP_SUB:  alu_res = reg_a - reg_b;
            OP_AND:  alu_res = reg_a & reg_b;
            OP_OR:   alu_res = reg_a | reg_b;
            OP_XOR:  alu_res = reg_a ^ reg_b;
            OP_NOR:  alu_res = ~(reg_a | reg_b);
            OP_SRA:  alu_res = (reg_b >= SHIFT_LIM) ? {NB_DATA{reg_a[NB_DATA-1]}}
                                                     : sra_val;
            OP_SRL:  alu_res = (reg_b >= SHIFT_LIM) ? '0 : (reg_a >> reg_b);
            default: alu_res = '0;
        endcase
    end

    // Strobes are registered on entry to POP_x / WR, so they are high exactly
    // while the FSM sits in those states.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= WAIT_A;
            reg_a   <= '0;
            reg_b   <= '0;
            reg_op  <= '0;
            result  <= '0;
            o_rx_rd <= 1'b0;
            o_tx_wr <= 1'b0;
        end else begin
            o_rx_rd <= 1'b0;
            o_tx_wr <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (!i_rx_empty) begin
                        reg_a   <= i_rx_data;
                        o_rx_rd <= 1'b1;
                        state   <= POP_A;
                    end
                end
                POP_A: state <= WAIT_B;
                WAIT_B: begin
                    if (!i_rx_empty) begin
                        reg_b   <= i_rx_data;
                        o_rx_rd <= 1'b1;
                        state   <= POP_B;
                    end
                end
                POP_B: state <= WAIT_OP;
                WAIT_OP: begin
                    if (!i_rx_empty) begin
                        reg_op  <= i_rx_data[NB_OP-1:0];
                        o_rx_rd <= 1'b1;
                        state   <= POP_OP;
                    end
                end
                POP_OP: state <= EXEC;
                EXEC: begin
                    result <= alu_res;
                    state  <= SEND;
                end
                SEND: begin
                    if (!i_tx_full) begin
                        o_tx_wr <= 1'b1;
                        state   <= WR;
                    end
                end
                WR:      state <= WAIT_A;
                default: state <= WAIT_A;
            endcase
        end
    end

    assign o_tx_data = result;
    assign o_result  = result;

endmodule
